// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Measures an incoming PWM waveform and recovers its duty code. The input
//   is synchronised, the high time and full period (rising edge to rising
//   edge) are counted in clk cycles, and a restoring divider turns the pair
//   into floor(high_time * 2^DUTY_W / period). Lines that stop toggling are
//   reported through the stuck_hi / stuck_lo levels.
//
// Parameters
//   CNT_W       counter width; timeout after 2^CNT_W-1 cycles
//   DUTY_W      width of the recovered duty code
//   SYNC_STAGES synchroniser depth (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   pwm_in     asynchronous PWM input
//   high_time  high cycles of the last complete period
//   period     cycles between the last two rising edges
//   duty       recovered duty code, saturated to 2^DUTY_W-1
//   valid      1-cycle pulse when high_time/period/duty update together
//   overrun    1-cycle pulse when a completed measurement is dropped
//   stuck_hi   level: input held high for the timeout
//   stuck_lo   level: input held low for the timeout
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int DUTY_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_time,
    output logic [CNT_W-1:0]  period,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              overrun,
    output logic              stuck_hi,
    output logic              stuck_lo
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam int                IT_W     = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    // -----------------------------------------------------------------------
    // Synchroniser and edge detector
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   s_d;
    logic                   armed;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   rise_a;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // fill_q tracks which synchroniser stages hold real samples rather than
    // reset zeros. armed is set once a genuine low level has been seen, so a
    // line that is already high when reset releases does not look like a
    // rising edge and the partial period around reset is never measured.
    // armed stays set in HIGH and LOW, so rise_a equals rise there.
    assign rise_a = rise & armed;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, exactly like hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            s_d    <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            s_d    <= s;
            armed  <= armed | (fill_q[SYNC_STAGES-1] & ~s);
        end
    end

    // -----------------------------------------------------------------------
    // Measurement FSM
    // -----------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_tmp_q;
    logic             timeout;
    logic             complete;
    logic             hi_latch;
    logic             tmo_hi;
    logic             tmo_lo;

    // Once a stuck flag is set the saturated counter must not re-fire.
    assign timeout = (cnt_q == CNT_MAX) & ~stuck_hi & ~stuck_lo;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rise_a) state_d = HIGH;
            HIGH: begin
                if (timeout)   state_d = IDLE;
                else if (fall) state_d = LOW;
            end
            LOW: begin
                if (rise_a)       state_d = HIGH;
                else if (timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // IDLE still counts so a line that never toggles after reset is
    // reported; the stuck level there is whatever the line currently reads.
    always_comb begin
        complete = (state_q == LOW) & rise_a;
        hi_latch = (state_q == HIGH) & fall & ~timeout;
        tmo_hi   = ~rise_a & timeout &
                   ((state_q == HIGH) | ((state_q == IDLE) & s));
        tmo_lo   = ~rise_a & timeout &
                   ((state_q == LOW) | ((state_q == IDLE) & ~s));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            hi_tmp_q <= '0;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
        end else begin
            if (rise_a)                cnt_q <= CNT_W'(1);
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;

            if (hi_latch) hi_tmp_q <= cnt_q;

            if (rise_a) begin
                stuck_hi <= 1'b0;
                stuck_lo <= 1'b0;
            end else if (tmo_hi) begin
                stuck_hi <= 1'b1;
            end else if (tmo_lo) begin
                stuck_lo <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Restoring divider: one quotient bit per cycle. The remainder starts at
    // m_high and is shifted left each step, which is the running top of the
    // CNT_W+DUTY_W-bit numerator m_high << DUTY_W; since rem < period it
    // never needs more than CNT_W+1 bits before the subtract.
    // -----------------------------------------------------------------------
    logic              busy_q;
    logic [IT_W-1:0]   it_q;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  den_q;
    logic [CNT_W-1:0]  num_hi_q;
    logic [DUTY_W-1:0] quo_q;
    logic              sat_q;
    logic [CNT_W:0]    rem_sh;
    logic              ge;
    logic [CNT_W-1:0]  rem_nx;
    logic [DUTY_W-1:0] quo_nx;
    logic              div_done;
    logic              accept;

    always_comb begin
        rem_sh   = {rem_q, 1'b0};
        ge       = rem_sh >= {1'b0, den_q};
        rem_nx   = ge ? CNT_W'(rem_sh - {1'b0, den_q}) : rem_sh[CNT_W-1:0];
        quo_nx   = (quo_q << 1) | DUTY_W'(ge);
        div_done = busy_q & (it_q == '0);
        // busy_q is already low in the cycle valid is shown, so a completion
        // that coincides with valid is accepted.
        accept   = complete & ~busy_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            it_q     <= '0;
            rem_q    <= '0;
            den_q    <= '0;
            num_hi_q <= '0;
            quo_q    <= '0;
            sat_q    <= 1'b0;
        end else if (accept) begin
            busy_q   <= 1'b1;
            it_q     <= IT_W'(DUTY_W - 1);
            rem_q    <= hi_tmp_q;
            den_q    <= cnt_q;
            num_hi_q <= hi_tmp_q;
            quo_q    <= '0;
            sat_q    <= hi_tmp_q >= cnt_q;
        end else if (busy_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            it_q  <= it_q - 1'b1;
            if (div_done) busy_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers. A timeout overrides a result finishing the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            high_time <= '0;
            period    <= '0;
            duty      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= complete & busy_q;
            if (tmo_hi) begin
                high_time <= CNT_MAX;
                period    <= CNT_MAX;
                duty      <= DUTY_MAX;
            end else if (tmo_lo) begin
                high_time <= '0;
                period    <= CNT_MAX;
                duty      <= '0;
            end else if (div_done) begin
                high_time <= num_hi_q;
                period    <= den_q;
                duty      <= sat_q ? DUTY_MAX : quo_nx;
                valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//   Directed bench for pwm_capture (CNT_W=6 so timeouts are short). A
//   background generator drives pwm_in as held-low, held-high or a PWM
//   stream of gen_h high cycles out of gen_p; each task sets the generator
//   and checks the DUT outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int CNT_W  = 6;
    localparam int DUTY_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pwm_in;
    logic [CNT_W-1:0]  high_time;
    logic [CNT_W-1:0]  period;
    logic [DUTY_W-1:0] duty;
    logic              valid;
    logic              overrun;
    logic              stuck_hi;
    logic              stuck_lo;

    int passed = 0;
    int total  = 0;

    // generator control: 0 = low, 1 = high, 2 = pwm
    int gen_mode = 0;
    int gen_h    = 0;
    int gen_p    = 16;
    int phase    = 0;
    int cur_h    = 0;

    pwm_capture #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .high_time (high_time),
        .period    (period),
        .duty      (duty),
        .valid     (valid),
        .overrun   (overrun),
        .stuck_hi  (stuck_hi),
        .stuck_lo  (stuck_lo)
    );

    always #5 clk = ~clk;

    // New h/p take effect at the start of a period only.
    initial begin
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (gen_mode)
                0: pwm_in = 1'b0;
                1: pwm_in = 1'b1;
                default: begin
                    if (phase == 0) cur_h = gen_h;
                    pwm_in = (phase < cur_h);
                    phase  = (phase + 1) % gen_p;
                end
            endcase
        end
    end

    task automatic set_pwm(input int h, input int p);
        gen_h    = h;
        gen_p    = p;
        phase    = 0;
        gen_mode = 2;
    endtask

    // Waits (bounded) for the next valid pulse, sampled on negedges.
    task automatic wait_valid(input int budget, output bit ok, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < budget);
        ok = valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (valid !== 1'b0)    $display("FAIL reset_valid: got %0b want 0", valid);    else passed++;
        total++; if (overrun !== 1'b0)  $display("FAIL reset_overrun: got %0b want 0", overrun); else passed++;
        total++; if (stuck_hi !== 1'b0) $display("FAIL reset_stuck_hi: got %0b want 0", stuck_hi); else passed++;
        total++; if (stuck_lo !== 1'b0) $display("FAIL reset_stuck_lo: got %0b want 0", stuck_lo); else passed++;
        total++; if (high_time !== '0)  $display("FAIL reset_high_time: got %0d want 0", high_time); else passed++;
        total++; if (period !== '0)     $display("FAIL reset_period: got %0d want 0", period);   else passed++;
        total++; if (duty !== '0)       $display("FAIL reset_duty: got %0d want 0", duty);       else passed++;
        rst = 1'b0;
    endtask

    task automatic test_gen5;
        bit ok;
        int n;
        set_pwm(5, 16);
        wait_valid(100, ok, n);
        total++; if (!ok) $display("FAIL gen5_first_valid: got none want pulse within 100"); else passed++;
        for (int k = 0; k < 3; k++) begin
            wait_valid(40, ok, n);
            total++; if (!ok || n != 16) $display("FAIL gen5_interval: got %0d want 16", n); else passed++;
            total++; if (high_time !== 6'd5) $display("FAIL gen5_high_time: got %0d want 5", high_time); else passed++;
            total++; if (period !== 6'd16)   $display("FAIL gen5_period: got %0d want 16", period);      else passed++;
            total++; if (duty !== 4'd5)      $display("FAIL gen5_duty: got %0d want 5", duty);           else passed++;
        end
    endtask

    task automatic test_sweep;
        bit ok;
        int n;
        for (int h = 1; h <= 15; h++) begin
            @(negedge clk);
            gen_h = h;
            wait_valid(60, ok, n);
            wait_valid(40, ok, n);
            total++; if (!ok) $display("FAIL sweep_valid h=%0d: got none want pulse", h); else passed++;
            total++; if (duty !== DUTY_W'(h))     $display("FAIL sweep_duty h=%0d: got %0d want %0d", h, duty, h); else passed++;
            total++; if (high_time !== CNT_W'(h)) $display("FAIL sweep_high_time h=%0d: got %0d want %0d", h, high_time, h); else passed++;
            total++; if (period !== 6'd16)        $display("FAIL sweep_period h=%0d: got %0d want 16", h, period); else passed++;
        end
    endtask

    task automatic test_stuck_lo;
        bit ok;
        int n;
        int vcount;
        @(negedge clk);
        gen_mode = 0;
        repeat (30) @(negedge clk);
        vcount = 0;
        n = 0;
        while (!stuck_lo && n < 150) begin
            @(negedge clk);
            n++;
            if (valid) vcount++;
        end
        total++; if (stuck_lo !== 1'b1)  $display("FAIL stuck_lo_set: got %0b want 1", stuck_lo);     else passed++;
        total++; if (stuck_hi !== 1'b0)  $display("FAIL stuck_lo_hi_flag: got %0b want 0", stuck_hi); else passed++;
        total++; if (high_time !== '0)   $display("FAIL stuck_lo_high_time: got %0d want 0", high_time); else passed++;
        total++; if (period !== 6'd63)   $display("FAIL stuck_lo_period: got %0d want 63", period);   else passed++;
        total++; if (duty !== '0)        $display("FAIL stuck_lo_duty: got %0d want 0", duty);         else passed++;
        total++; if (vcount != 0)        $display("FAIL stuck_lo_no_valid: got %0d want 0", vcount);   else passed++;
        set_pwm(8, 16);
        n = 0;
        while (stuck_lo && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++; if (stuck_lo !== 1'b0) $display("FAIL stuck_lo_clear: got %0b want 0", stuck_lo); else passed++;
        wait_valid(60, ok, n);
        total++; if (!ok) $display("FAIL stuck_lo_recover_valid: got none want pulse"); else passed++;
        total++; if (duty !== 4'd8)      $display("FAIL stuck_lo_recover_duty: got %0d want 8", duty);       else passed++;
        total++; if (high_time !== 6'd8) $display("FAIL stuck_lo_recover_high: got %0d want 8", high_time); else passed++;
        total++; if (period !== 6'd16)   $display("FAIL stuck_lo_recover_period: got %0d want 16", period); else passed++;
    endtask

    task automatic test_stuck_hi;
        int n;
        int vcount;
        @(negedge clk);
        gen_mode = 1;
        repeat (30) @(negedge clk);
        vcount = 0;
        n = 0;
        while (!stuck_hi && n < 150) begin
            @(negedge clk);
            n++;
            if (valid) vcount++;
        end
        total++; if (stuck_hi !== 1'b1)   $display("FAIL stuck_hi_set: got %0b want 1", stuck_hi);       else passed++;
        total++; if (stuck_lo !== 1'b0)   $display("FAIL stuck_hi_lo_flag: got %0b want 0", stuck_lo);   else passed++;
        total++; if (high_time !== 6'd63) $display("FAIL stuck_hi_high_time: got %0d want 63", high_time); else passed++;
        total++; if (period !== 6'd63)    $display("FAIL stuck_hi_period: got %0d want 63", period);     else passed++;
        total++; if (duty !== 4'd15)      $display("FAIL stuck_hi_duty: got %0d want 15", duty);         else passed++;
        total++; if (vcount != 0)         $display("FAIL stuck_hi_no_valid: got %0d want 0", vcount);    else passed++;
    endtask

    task automatic test_back_to_back;
        int vcount;
        int ocount;
        set_pwm(1, 2);
        repeat (20) @(negedge clk);
        total++; if (stuck_hi !== 1'b0) $display("FAIL b2b_stuck_clear: got %0b want 0", stuck_hi); else passed++;
        vcount = 0;
        ocount = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (overrun) ocount++;
            if (valid) begin
                vcount++;
                total++; if (high_time !== 6'd1) $display("FAIL b2b_high_time: got %0d want 1", high_time); else passed++;
                total++; if (period !== 6'd2)    $display("FAIL b2b_period: got %0d want 2", period);       else passed++;
                total++; if (duty !== 4'd8)      $display("FAIL b2b_duty: got %0d want 8", duty);           else passed++;
            end
        end
        total++; if (vcount == 0) $display("FAIL b2b_valid_count: got 0 want >0"); else passed++;
        total++; if (ocount == 0) $display("FAIL b2b_overrun_count: got 0 want >0"); else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        bit prev;
        bit seen_ovr;
        set_pwm(10, 16);
        wait_valid(80, ok, n);
        wait_valid(40, ok, n);
        // find the start of a high phase, then reset while the DUT is in HIGH
        prev = pwm_in;
        n = 0;
        do begin
            prev = pwm_in;
            @(negedge clk);
            n++;
        end while (!(pwm_in && !prev) && n < 40);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL mid_reset_pulses: got valid=%0b overrun=%0b want 0 0", valid, overrun); else passed++;
        total++; if (high_time !== '0 || period !== '0 || duty !== '0)
            $display("FAIL mid_reset_data: got %0d/%0d/%0d want 0/0/0", high_time, period, duty); else passed++;
        total++; if (stuck_hi !== 1'b0 || stuck_lo !== 1'b0)
            $display("FAIL mid_reset_stuck: got %0b%0b want 00", stuck_hi, stuck_lo); else passed++;
        rst = 1'b0;
        seen_ovr = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (overrun) seen_ovr = 1'b1;
        end while (!valid && n < 80);
        total++; if (!valid)             $display("FAIL mid_reset_valid: got none want pulse");           else passed++;
        total++; if (duty !== 4'd10)     $display("FAIL mid_reset_duty: got %0d want 10", duty);          else passed++;
        total++; if (high_time !== 6'd10) $display("FAIL mid_reset_high: got %0d want 10", high_time);    else passed++;
        total++; if (period !== 6'd16)   $display("FAIL mid_reset_period: got %0d want 16", period);      else passed++;
        total++; if (seen_ovr)           $display("FAIL mid_reset_overrun: got 1 want 0");                 else passed++;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_gen5();
        test_sweep();
        test_stuck_lo();
        test_stuck_hi();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
